// File: rtl/reg_readout_ctrl.sv
// Register-range readout: walks rd_sel from a latched first index to a latched
// last index (wrapping past NUM_REGS-1) and streams each word on a valid/ready port.
module reg_readout_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  first_reg,
  input  logic [SEL_WIDTH-1:0]  last_reg,
  output logic [SEL_WIDTH-1:0]  rd_sel,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_dbg
);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_idx hold steady until then.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [SEL_WIDTH-1:0] MAX_IDX = SEL_WIDTH'(NUM_REGS - 1);

  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] last_q;
  logic [SEL_WIDTH-1:0] first_c;
  logic [SEL_WIDTH-1:0] last_c;
  logic [SEL_WIDTH-1:0] next_ptr;

  assign state_dbg = state;

  always_comb begin
    first_c  = first_reg;
    last_c   = last_reg;
    next_ptr = ptr + 1'b1;
    if (first_reg > MAX_IDX) first_c = MAX_IDX;
    if (last_reg > MAX_IDX)  last_c  = MAX_IDX;
    if (ptr == MAX_IDX)      next_ptr = '0;
  end

  // rd_sel/rd_en are registered so they are already valid during the READ cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      ptr       <= '0;
      last_q    <= '0;
      rd_sel    <= '0;
      rd_en     <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr    <= first_c;
            last_q <= last_c;
            rd_sel <= first_c;
            rd_en  <= 1'b1;
            busy   <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          out_data  <= rd_data;
          out_idx   <= ptr;
          out_valid <= 1'b1;
          rd_en     <= 1'b0;
          rd_sel    <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr == last_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ptr    <= next_ptr;
              rd_sel <= next_ptr;
              rd_en  <= 1'b1;
              state  <= S_READ;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readout_ctrl.sv
// Bench for reg_readout_ctrl: directed latency/stall/reset scenarios plus random
// dumps scored against an index-queue model of the requested register range.
module tb_reg_readout_ctrl;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 5;

  logic          clk;
  logic          clr;
  logic          start;
  logic [SW-1:0] first_reg;
  logic [SW-1:0] last_reg;
  logic [SW-1:0] rd_sel;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  logic [DW-1:0] regs [0:(1<<SW)-1];
  logic [SW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  reg_readout_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
    .clk(clk), .clr(clr), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_sel(rd_sel), .rd_en(rd_en), .rd_data(rd_data), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  assign rd_data = regs[rd_sel];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: ordered list of indices a dump of [f..l] must produce
  task automatic build_exp(input int f, input int l);
    int i;
    int lc;
    exp_q.delete();
    i  = (f > NR - 1) ? NR - 1 : f;
    lc = (l > NR - 1) ? NR - 1 : l;
    forever begin
      exp_q.push_back(SW'(i));
      if (i == lc) break;
      i = (i + 1) % NR;
    end
  endtask

  task automatic init_regs_fixed();
    for (int i = 0; i < (1 << SW); i++) regs[i] = 32'h1000_0000 + i;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({rd_sel, rd_en, out_data, out_idx, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: rd_sel=%0d rd_en=%b data=%h idx=%0d valid=%b busy=%b done=%b",
               tag, rd_sel, rd_en, out_data, out_idx, out_valid, busy, done);
    end
  endtask

  // Generic dump with random consumer stalls, scored against exp_q.
  task automatic run_dump(input int f, input int l, input int ready_pct, input string tag);
    int cyc;
    bit fin;
    logic [SW-1:0] e;
    build_exp(f, l);
    start = 1'b1; first_reg = SW'(f); last_reg = SW'(l); out_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 0; fin = 0;
    while (!fin && cyc < 400) begin
      if (rd_en) begin
        checks++;
        if (exp_q.size() == 0 || rd_sel !== exp_q[0]) begin
          errors++;
          $display("FAIL %s rd_sel got %0d exp %0d", tag, rd_sel, (exp_q.size() != 0) ? exp_q[0] : 0);
        end
      end else begin
        checks++;
        if (rd_sel !== '0) begin
          errors++; $display("FAIL %s rd_sel idle got %0d exp 0", tag, rd_sel);
        end
      end
      if (out_valid && rd_en) begin
        checks++; errors++;
        $display("FAIL %s rd_en=%b while out_valid=%b, exp rd_en=0", tag, rd_en, out_valid);
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++; $display("FAIL %s done early, %0d words left exp 0", tag, exp_q.size());
        end
        fin = 1;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      start = (busy && !done) ? 1'($urandom_range(1)) : 1'b0;
      first_reg = SW'($urandom_range(31));
      last_reg  = SW'($urandom_range(31));
      if (fin) start = 1'b0;
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        checks++;
        if (out_idx !== e || out_data !== regs[e]) begin
          errors++;
          $display("FAIL %s word got idx=%0d data=%h exp idx=%0d data=%h", tag, out_idx, out_data, e, regs[e]);
        end
      end
      step();
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout done=%b exp 1", tag, done);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s after done busy=%b done=%b exp 0 0", tag, busy, done);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
    #2;
    check_all_zero("reset_async");
    step(); step();
    check_all_zero("reset_held");
    clr = 1'b1;
    step();
    check_all_zero("reset_release_idle");
  endtask

  task automatic test_clr_mid_dump();
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd15; out_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 clr = 1'b0;
    #1 check_all_zero("clr_mid_immediate");
    step(); step(); step();
    check_all_zero("clr_mid_held");
    clr = 1'b1;
    step();
    run_dump(3, 5, 100, "after_clr");
  endtask

  task automatic test_latency();
    logic exp_valid, exp_rd, exp_done, exp_busy;
    logic [SW-1:0] exp_idx;
    start = 1'b1; first_reg = 5'd2; last_reg = 5'd4; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp_valid = (c >= 2 && c <= 6 && c % 2 == 0);
      exp_rd    = (c == 1 || c == 3 || c == 5);
      exp_done  = (c == 7);
      exp_busy  = (c >= 1 && c <= 7);
      exp_idx   = SW'(2 + (c - 1) / 2);
      checks++;
      if (out_valid !== exp_valid || rd_en !== exp_rd || done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL latency c%0d valid=%b rd_en=%b done=%b busy=%b exp %b %b %b %b",
                 c, out_valid, rd_en, done, busy, exp_valid, exp_rd, exp_done, exp_busy);
      end
      if (exp_valid) begin
        checks++;
        if (out_idx !== exp_idx || out_data !== 32'h1000_0000 + exp_idx) begin
          errors++;
          $display("FAIL latency_word c%0d idx=%0d data=%h exp idx=%0d data=%h",
                   c, out_idx, out_data, exp_idx, 32'h1000_0000 + exp_idx);
        end
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int guard;
    start = 1'b1; first_reg = 5'd5; last_reg = 5'd6; out_ready = 1'b0;
    step();
    start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin step(); guard++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1000_0005 || out_idx !== 5'd5 || rd_en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall c%0d valid=%b data=%h idx=%0d rd_en=%b busy=%b exp 1 10000005 5 0 1",
                 c, out_valid, out_data, out_idx, rd_en, busy);
      end
      start = (c == 2); first_reg = 5'd0; last_reg = 5'd0;
      step();
    end
    start = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (rd_en !== 1'b1 || rd_sel !== 5'd6) begin
      errors++; $display("FAIL stall_read rd_en=%b rd_sel=%0d exp 1 6", rd_en, rd_sel);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd6 || out_data !== 32'h1000_0006) begin
      errors++; $display("FAIL stall_word2 valid=%b idx=%0d data=%h exp 1 6 10000006", out_valid, out_idx, out_data);
    end
    step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stall_done done=%b exp 1", done);
    end
    out_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL stall_end busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_wrap_single_clamp();
    run_dump(14, 1, 100, "wrap_14_1");
    run_dump(15, 0, 50, "wrap_15_0");
    run_dump(7, 7, 100, "single_7");
    run_dump(20, 20, 100, "clamp_20");
    run_dump(3, 25, 70, "clamp_last");
  endtask

  task automatic test_clr_in_hold();
    int guard;
    start = 1'b1; first_reg = 5'd8; last_reg = 5'd9; out_ready = 1'b0;
    step();
    start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin step(); guard++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_reach valid=%b exp 1", out_valid);
    end
    #3 clr = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL clr_hold valid=%b busy=%b data=%h exp 0 0 0", out_valid, busy, out_data);
    end
    step();
    clr = 1'b1;
    step();
    run_dump(0, 0, 100, "after_hold_clr");
  endtask

  task automatic test_random();
    for (int i = 0; i < (1 << SW); i++) regs[i] = $urandom;
    for (int n = 0; n < 12; n++)
      run_dump($urandom_range(31), $urandom_range(31), $urandom_range(30, 100), "random");
  endtask

  initial begin
    init_regs_fixed();
    test_reset();
    test_clr_mid_dump();
    test_latency();
    test_stall();
    test_wrap_single_clamp();
    test_clr_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
